// File: rtl/spi_slave_fifo_pkg.sv
// Shared constants and helpers for the SPI slave FIFO block.
// Mode encoding is {CPOL,CPHA}.
package spi_pkg;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_DEPTH = 4;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/spi_slave_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers.
// A push while full is taken only when a pop happens in the same cycle.
module sync_fifo
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      empty   = (wptr_q == rptr_q);
      full    = (wptr_q[AW] != rptr_q[AW]) &&
                (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      wptr_d  = do_push ? wptr_q + ONE : wptr_q;
      rptr_d  = do_pop ? rptr_q + ONE : rptr_q;
      dout    = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: oversampling SPI slave with RX/TX word FIFOs.
// Define SPI_SLAVE_LOOPBACK_EN to add the loopback echo input.
module spi_slave_fifo
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter bit          CPOL      = 1'b0,
   parameter bit          CPHA      = 1'b0,
   parameter bit          LSB_FIRST = 1'b0,
   parameter logic [31:0] IDLE_WORD = 32'h0
) (
   input  logic             CLK,
   input  logic             reset,
`ifdef SPI_SLAVE_LOOPBACK_EN
   input  logic             loopback,
`endif
   input  logic             SCK,
   input  logic             MOSI,
   output logic             MISO,
   input  logic             SSEL,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             rx_overflow,
   output logic             tx_underflow,
   output logic             busy
);

   localparam int unsigned   CW   = clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2:0]       sck_q, sck_d;
   logic [1:0]       mosi_q, mosi_d;
   logic [2:0]       ssel_q, ssel_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic             rx_commit_q, rx_commit_d;
   logic             rx_overflow_q, rx_overflow_d;
   logic             tx_underflow_q, tx_underflow_d;

   logic             active, ssel_fall, lead, trail;
   logic             sample, shift, tx_load;
   logic             rx_push, rx_pop, rx_full, rx_empty;
   logic             tx_push, tx_pop, tx_full, tx_empty;
   logic [WIDTH-1:0] tx_dout, tx_wdata;

   // Index [1] is the synchronised level, [2] the previous one.
   always_comb begin
      sck_d     = {sck_q[1:0], SCK};
      mosi_d    = {mosi_q[0], MOSI};
      ssel_d    = {ssel_q[1:0], SSEL};
      active    = ~ssel_q[1];
      ssel_fall = active & ssel_q[2];
      lead      = CPOL ? (~sck_q[1] & sck_q[2]) : (sck_q[1] & ~sck_q[2]);
      trail     = CPOL ? (sck_q[1] & ~sck_q[2]) : (~sck_q[1] & sck_q[2]);
      sample    = active & (CPHA ? trail : lead);
      shift     = active & (CPHA ? lead : trail);
   end

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      rx_commit_d = 1'b0;
      tx_load     = 1'b0;
      if (!active) begin
         bit_cnt_d = '0;
      end else begin
         if (sample) begin
            rx_shift_d = LSB_FIRST ? {mosi_q[1], rx_shift_q[WIDTH-1:1]}
                                   : {rx_shift_q[WIDTH-2:0], mosi_q[1]};
            if (bit_cnt_q == LAST) begin
               bit_cnt_d   = '0;
               rx_commit_d = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         // A shift edge at count zero opens a new word in both phases.
         if (shift) begin
            if (bit_cnt_q == '0) tx_load = 1'b1;
            else tx_shift_d = LSB_FIRST ? {1'b0, tx_shift_q[WIDTH-1:1]}
                                        : {tx_shift_q[WIDTH-2:0], 1'b0};
         end
         if (!CPHA && ssel_fall) tx_load = 1'b1;
      end
      if (tx_load) tx_shift_d = tx_empty ? IDLE_WORD[WIDTH-1:0] : tx_dout;
      tx_underflow_d = tx_load & tx_empty;
      rx_overflow_d  = rx_commit_q & rx_full;
   end

   always_comb begin
      rx_push  = rx_commit_q & ~rx_full;
      rx_valid = ~rx_empty;
      rx_pop   = rx_valid & rx_ready;
      tx_pop   = tx_load & ~tx_empty;
`ifdef SPI_SLAVE_LOOPBACK_EN
      tx_ready = ~tx_full & ~loopback;
      tx_push  = loopback ? (rx_push & ~tx_full) : (tx_valid & tx_ready);
      tx_wdata = loopback ? rx_shift_q : tx_data;
`else
      tx_ready = ~tx_full;
      tx_push  = tx_valid & tx_ready;
      tx_wdata = tx_data;
`endif
      MISO         = active & (LSB_FIRST ? tx_shift_q[0]
                                         : tx_shift_q[WIDTH-1]);
      busy         = active;
      rx_overflow  = rx_overflow_q;
      tx_underflow = tx_underflow_q;
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         sck_q          <= {3{CPOL}};
         mosi_q         <= '0;
         ssel_q         <= '1;
         bit_cnt_q      <= '0;
         rx_shift_q     <= '0;
         tx_shift_q     <= '0;
         rx_commit_q    <= 1'b0;
         rx_overflow_q  <= 1'b0;
         tx_underflow_q <= 1'b0;
      end else begin
         sck_q          <= sck_d;
         mosi_q         <= mosi_d;
         ssel_q         <= ssel_d;
         bit_cnt_q      <= bit_cnt_d;
         rx_shift_q     <= rx_shift_d;
         tx_shift_q     <= tx_shift_d;
         rx_commit_q    <= rx_commit_d;
         rx_overflow_q  <= rx_overflow_d;
         tx_underflow_q <= tx_underflow_d;
      end
   end

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
      .CLK   (CLK),
      .reset (reset),
      .push  (rx_push),
      .din   (rx_shift_q),
      .pop   (rx_pop),
      .full  (rx_full),
      .empty (rx_empty),
      .dout  (rx_data)
   );

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
      .CLK   (CLK),
      .reset (reset),
      .push  (tx_push),
      .din   (tx_wdata),
      .pop   (tx_pop),
      .full  (tx_full),
      .empty (tx_empty),
      .dout  (tx_dout)
   );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: four instances, one per SPI mode,
// driven by a bit-level master against a word-level queue model.
module tb_spi_slave_fifo;

   localparam int HALF = 80;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0] sck, mosi, ssel, miso;
   logic [3:0] rx_valid, rx_ready, tx_valid, tx_ready;
   logic [3:0] rx_ovf, tx_udf, busy;
   logic [3:0][11:0] rx_data, tx_data;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W = (g == 0) ? 8 : 12;
      logic [W-1:0] rxd;
      spi_slave_fifo #(
         .WIDTH(W), .DEPTH(4), .CPOL(g >= 2), .CPHA(g % 2 == 1),
         .LSB_FIRST(g != 0), .IDLE_WORD(32'hFF)
      ) u_dut (
         .CLK(clk), .reset(rst), .SCK(sck[g]), .MOSI(mosi[g]),
         .MISO(miso[g]), .SSEL(ssel[g]), .rx_data(rxd),
         .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
         .tx_data(W'(tx_data[g])), .tx_valid(tx_valid[g]),
         .tx_ready(tx_ready[g]), .rx_overflow(rx_ovf[g]),
         .tx_underflow(tx_udf[g]), .busy(busy[g])
      );
      assign rx_data[g] = 12'(rxd);
   end

   int total = 0;
   int bad = 0;
   logic [31:0] m_tx [4][$];
   logic [31:0] m_rx [4][$];
   int exp_ovf [4] = '{default: 0};
   int exp_udf [4] = '{default: 0};
   int obs_ovf [4] = '{default: 0};
   int obs_udf [4] = '{default: 0};
   logic [31:0] mwords [8];
   time t_lead = 0;
   time t_rxv = 0;

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rx_ovf[i]) obs_ovf[i] <= obs_ovf[i] + 1;
         if (tx_udf[i]) obs_udf[i] <= obs_udf[i] + 1;
      end
   end

   always @(posedge rx_valid[0]) t_rxv = $time;

   function automatic int wid(int m);
      return (m == 0) ? 8 : 12;
   endfunction

   function automatic logic [31:0] msk(int m);
      return (32'd1 << wid(m)) - 32'd1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(int m);
      chk($sformatf("rst_miso%0d", m), miso[m], 0);
      chk($sformatf("rst_rxv%0d", m), rx_valid[m], 0);
      chk($sformatf("rst_rxd%0d", m), rx_data[m], 0);
      chk($sformatf("rst_txr%0d", m), tx_ready[m], 1);
      chk($sformatf("rst_ovf%0d", m), rx_ovf[m], 0);
      chk($sformatf("rst_udf%0d", m), tx_udf[m], 0);
      chk($sformatf("rst_busy%0d", m), busy[m], 0);
   endtask

   task automatic push_tx(int m, logic [31:0] v);
      @(negedge clk);
      chk($sformatf("tx_ready%0d", m), tx_ready[m], m_tx[m].size() < 4);
      tx_data[m]  = v[11:0];
      tx_valid[m] = 1'b1;
      @(negedge clk);
      tx_valid[m] = 1'b0;
      m_tx[m].push_back(v & msk(m));
   endtask

   task automatic sel(int m);
      ssel[m] = 1'b0;
      #HALF;
   endtask

   task automatic desel(int m);
      #HALF;
      ssel[m] = 1'b1;
      #(4 * HALF);
   endtask

   // Master side of nb bits; wi collects MISO in word bit positions.
   task automatic xfer(int m, logic [31:0] wo, int nb,
                       output logic [31:0] wi);
      bit cpol, cpha;
      int b;
      cpol = (m >= 2);
      cpha = (m % 2 == 1);
      wi = '0;
      for (int i = 0; i < nb; i++) begin
         b = (m == 0) ? wid(m) - 1 - i : i;
         if (!cpha) begin
            mosi[m] = wo[b];
            #HALF;
            wi[b] = miso[m];
            sck[m] = ~cpol;
            if (m == 0) t_lead = $time;
            #HALF;
            sck[m] = cpol;
         end else begin
            sck[m] = ~cpol;
            mosi[m] = wo[b];
            #HALF;
            wi[b] = miso[m];
            sck[m] = cpol;
            #HALF;
         end
      end
   endtask

   task automatic model_load(int m, inout logic [31:0] ld [$]);
      if (m_tx[m].size() > 0) ld.push_back(m_tx[m].pop_front());
      else begin
         ld.push_back(32'hFF & msk(m));
         exp_udf[m]++;
      end
   endtask

   // n full words from mwords, then an optional ab-bit partial word.
   task automatic xact(int m, int n, int ab);
      logic [31:0] got;
      logic [31:0] ld [$];
      int nl;
      nl = (m % 2 == 1) ? n + ((ab > 0) ? 1 : 0) : n + 1;
      for (int k = 0; k < nl; k++) model_load(m, ld);
      sel(m);
      chk($sformatf("busy%0d", m), busy[m], 1);
      for (int k = 0; k < n; k++) begin
         xfer(m, mwords[k], wid(m), got);
         chk($sformatf("miso_m%0d_w%0d", m, k), got, ld[k]);
         if (m_rx[m].size() < 4) m_rx[m].push_back(mwords[k] & msk(m));
         else exp_ovf[m]++;
      end
      if (ab > 0) xfer(m, 32'h0, ab, got);
      desel(m);
      chk($sformatf("udf_cnt%0d", m), obs_udf[m], exp_udf[m]);
      chk($sformatf("ovf_cnt%0d", m), obs_ovf[m], exp_ovf[m]);
   endtask

   task automatic drain(int m);
      while (m_rx[m].size() > 0) begin
         @(negedge clk);
         chk($sformatf("rx_valid%0d", m), rx_valid[m], 1);
         chk($sformatf("rx_data%0d", m), rx_data[m], m_rx[m].pop_front());
         rx_ready[m] = 1'b1;
         @(negedge clk);
         rx_ready[m] = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("rx_drained%0d", m), rx_valid[m], 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      int n, k, nl, d0;
      rst = 1'b1;
      sck = 4'b1100;
      mosi = '0;
      ssel = '1;
      rx_ready = '0;
      tx_valid = '0;
      tx_data = '0;
      #23;
      for (int m = 0; m < 4; m++) chk_reset(m);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      push_tx(0, 32'hA5);
      mwords[0] = 32'h3C;
      xact(0, 1, 0);
      chk("rx_latency", (t_rxv > t_lead) && (t_rxv - t_lead <= 60), 1);
      drain(0);

      for (int m = 1; m < 4; m++) begin
         push_tx(m, 32'h123);
         mwords[0] = 32'hABC;
         xact(m, 1, 0);
         drain(m);
      end

      repeat (3) begin
         for (int m = 0; m < 4; m++) begin
            n = $urandom_range(1, 3);
            nl = (m % 2 == 1) ? n : n + 1;
            k = $urandom_range(0, nl);
            for (int i = 0; i < k; i++) push_tx(m, $urandom);
            for (int i = 0; i < n; i++) mwords[i] = $urandom;
            xact(m, n, 0);
            drain(m);
         end
      end

      for (int i = 0; i < 5; i++) mwords[i] = i + 1;
      xact(0, 5, 0);
      drain(0);

      d0 = obs_udf[1];
      for (int i = 0; i < 2; i++) mwords[i] = $urandom;
      xact(1, 2, 0);
      chk("udf_twice", obs_udf[1] - d0, 2);
      drain(1);

      xact(0, 0, 3);
      mwords[0] = 32'h5A;
      xact(0, 1, 0);
      chk("bit_cnt_idle", 32'(g_dut[0].u_dut.bit_cnt_q), 0);
      drain(0);

      for (int i = 0; i < 2; i++) mwords[i] = $urandom;
      xact(0, 2, 0);
      @(negedge clk);
      chk("pre_rst_rxv", rx_valid[0], 1);
      begin
         logic [31:0] ld [$];
         model_load(0, ld);
      end
      sel(0);
      xfer(0, 32'hC3, 4, got);
      #(HALF / 2);
      rst = 1'b1;
      #1;
      chk_reset(0);
      ssel[0] = 1'b1;
      m_rx[0].delete();
      m_tx[0].delete();
      repeat (4) @(negedge clk);
      chk("udf_before_rst", obs_udf[0], exp_udf[0]);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      mwords[0] = $urandom;
      xact(0, 1, 0);
      drain(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
